demux1_to_4_buf: RTL and testbench

DEMUX1_TO_4_BUF -- requirements
Module: demux1_to_4_buf

---
 rtl/demux1_to_4_buf.sv | 123 ++++++++++++
 tb/tb_demux1_to_4_buf.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux1_to_4_buf.sv
// 1-to-4 demultiplexer with a one-entry output buffer per channel.
// Define DEMUX_XFER_COUNT_EN to add saturating per-channel drain counters (cnt0..cnt3).

module demux1_to_4_buf_chan #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
`ifdef DEMUX_XFER_COUNT_EN
    ,
    output logic [7:0]       o_cnt
`endif
);
    logic             r_vq;
    logic [WIDTH-1:0] r_dq;
    logic             w_drain;

    assign w_drain = r_vq & i_ready;

    // Load wins over drain so a same-cycle drain+accept keeps the buffer full.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vq <= 1'b0;
            r_dq <= '0;
        end else if (i_load) begin
            r_vq <= 1'b1;
            r_dq <= i_data;
        end else if (w_drain) begin
            r_vq <= 1'b0;
        end
    end

`ifdef DEMUX_XFER_COUNT_EN
    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (w_drain && (r_cnt != 8'hFF))
            r_cnt <= r_cnt + 8'd1;
    end

    assign o_cnt = r_cnt;
`endif

    assign o_valid = r_vq;
    assign o_data  = r_dq;
endmodule

module demux1_to_4_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic [1:0]       sel,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready
`ifdef DEMUX_XFER_COUNT_EN
    ,
    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1,
    output logic [7:0]       cnt2,
    output logic [7:0]       cnt3
`endif
);
    logic [3:0]            w_vq;
    logic [3:0][WIDTH-1:0] w_dq;
    logic [3:0]            w_load;
    logic                  w_in_ready;
    logic                  w_accept;

    // A full channel can still accept if its sink drains on the same edge.
    assign w_in_ready = ~w_vq[sel] | out_ready[sel];
    assign w_accept   = in_valid & w_in_ready;

`ifdef DEMUX_XFER_COUNT_EN
    logic [3:0][7:0] w_cnt;
`endif

    for (genvar k = 0; k < 4; k++) begin : g_chan
        assign w_load[k] = w_accept & (sel == 2'(k));

        demux1_to_4_buf_chan #(.WIDTH(WIDTH)) u_chan (
            .clk     (clk),
            .rst     (rst),
            .i_load  (w_load[k]),
            .i_data  (in_data),
            .i_ready (out_ready[k]),
            .o_valid (w_vq[k]),
            .o_data  (w_dq[k])
`ifdef DEMUX_XFER_COUNT_EN
            ,
            .o_cnt   (w_cnt[k])
`endif
        );
    end

`ifdef DEMUX_XFER_COUNT_EN
    assign cnt0 = w_cnt[0];
    assign cnt1 = w_cnt[1];
    assign cnt2 = w_cnt[2];
    assign cnt3 = w_cnt[3];
`endif

    assign in_ready  = w_in_ready;
    assign out_valid = w_vq;
    assign out0      = w_dq[0];
    assign out1      = w_dq[1];
    assign out2      = w_dq[2];
    assign out3      = w_dq[3];
endmodule

// File: tb/tb_demux1_to_4_buf.sv
// Self-checking bench for demux1_to_4_buf: directed scenarios plus random traffic
// compared against a per-channel queue model.

module tb_demux1_to_4_buf;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic [1:0] sel;
    logic       in_ready;
    logic [7:0] out0, out1, out2, out3;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
`ifdef DEMUX_XFER_COUNT_EN
    logic [7:0] cnt0, cnt1, cnt2, cnt3;
    logic [7:0] dcnt [4];
`endif
    logic [7:0] dout [4];

    int errors = 0;
    int checks = 0;

    // Model: each channel is a FIFO of capacity one; the visible word is the last one accepted.
    logic [7:0] mq [4][$];
    logic [7:0] mlast [4];
    int         mcnt [4];

    always #5 clk = ~clk;

    demux1_to_4_buf #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .sel       (sel),
        .in_ready  (in_ready),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DEMUX_XFER_COUNT_EN
        ,
        .cnt0      (cnt0),
        .cnt1      (cnt1),
        .cnt2      (cnt2),
        .cnt3      (cnt3)
`endif
    );

    assign dout[0] = out0;
    assign dout[1] = out1;
    assign dout[2] = out2;
    assign dout[3] = out3;
`ifdef DEMUX_XFER_COUNT_EN
    assign dcnt[0] = cnt0;
    assign dcnt[1] = cnt1;
    assign dcnt[2] = cnt2;
    assign dcnt[3] = cnt3;
`endif

    function automatic logic [3:0] exp_vld();
        logic [3:0] v;
        for (int k = 0; k < 4; k++) v[k] = (mq[k].size() != 0);
        return v;
    endfunction

    function automatic logic exp_rdy();
        return (mq[sel].size() == 0) || out_ready[sel];
    endfunction

    // Advance one clock, updating the model from the inputs present before the edge.
    task automatic tick();
        bit         push;
        bit         pop [4];
        logic [1:0] s;
        logic [7:0] d;
        push = in_valid && exp_rdy();
        s    = sel;
        d    = in_data;
        for (int k = 0; k < 4; k++) pop[k] = (mq[k].size() != 0) && out_ready[k];
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                mq[k].delete();
                mlast[k] = 8'h00;
                mcnt[k]  = 0;
            end
        end else begin
            for (int k = 0; k < 4; k++)
                if (pop[k]) begin
                    void'(mq[k].pop_front());
                    if (mcnt[k] < 255) mcnt[k]++;
                end
            if (push) begin
                mq[s].push_back(d);
                mlast[s] = d;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; sel = 2'd0; in_data = 8'h00; out_ready = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid got=%b exp=%b", out_valid, 4'b0000); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (dout[k] !== 8'h00) begin errors++; $display("FAIL reset_out%0d got=%h exp=00", k, dout[k]); end
        end
    endtask

    task automatic test_routing();
        do_reset();
        in_valid = 1'b1; sel = 2'd2; in_data = 8'hA5; out_ready = 4'b0000;
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 4'b0100) begin errors++; $display("FAIL route_valid got=%b exp=0100", out_valid); end
        checks++;
        if (out2 !== 8'hA5) begin errors++; $display("FAIL route_out2 got=%h exp=a5", out2); end
    endtask

    task automatic test_backpressure();
        do_reset();
        in_valid = 1'b1; sel = 2'd1; in_data = 8'h11; out_ready = 4'b0000;
        tick();
        in_data = 8'h22;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_blocked got=%b exp=0", in_ready); end
        tick();
        checks++;
        if (out1 !== 8'h11 || out_valid[1] !== 1'b1) begin
            errors++; $display("FAIL bp_hold got=%h/%b exp=11/1", out1, out_valid[1]);
        end
        sel = 2'd3; in_data = 8'h33;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_other_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 4'b1010 || out3 !== 8'h33) begin
            errors++; $display("FAIL bp_other_fill got=%b/%h exp=1010/33", out_valid, out3);
        end
    endtask

    task automatic test_streaming();
        do_reset();
        out_ready = 4'b1111; in_valid = 1'b1; sel = 2'd0;
        for (int w = 1; w <= 4; w++) begin
            in_data = 8'(w);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready w=%0d got=%b exp=1", w, in_ready); end
            tick();
            checks++;
            if (out0 !== 8'(w) || out_valid[0] !== 1'b1) begin
                errors++; $display("FAIL stream_out0 got=%h/%b exp=%h/1", out0, out_valid[0], 8'(w));
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_parallel_drain();
        logic [7:0] vals [4];
        vals[0] = 8'd10; vals[1] = 8'd20; vals[2] = 8'd30; vals[3] = 8'd40;
        do_reset();
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sel = 2'(k); in_data = vals[k];
            tick();
        end
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 4'b1111) begin errors++; $display("FAIL par_full got=%b exp=1111", out_valid); end
        out_ready = 4'b1111;
        tick();
        out_ready = 4'b0000;
        #1;
        checks++;
        if (out_valid !== 4'b0000) begin errors++; $display("FAIL par_drain got=%b exp=0000", out_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_valid = 1'b1; sel = 2'd0; in_data = 8'h5A;
        tick();
        sel = 2'd3; in_data = 8'hC3;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready_during got=%b exp=1", in_ready); end
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 4'b0000) begin errors++; $display("FAIL rstmid_valid got=%b exp=0000", out_valid); end
        checks++;
        if ({out0, out1, out2, out3} !== 32'h0) begin
            errors++; $display("FAIL rstmid_data got=%h exp=00000000", {out0, out1, out2, out3});
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            in_valid  = $urandom_range(0, 3) != 0;
            sel       = 2'($urandom_range(0, 3));
            in_data   = 8'($urandom);
            out_ready = 4'($urandom);
            #1;
            if (!rst) begin
                checks++;
                if (in_ready !== exp_rdy()) begin
                    errors++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, in_ready, exp_rdy());
                end
            end
            tick();
            #1;
            checks++;
            if (out_valid !== exp_vld()) begin
                errors++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", c, out_valid, exp_vld());
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (dout[k] !== mlast[k]) begin
                    errors++; $display("FAIL rand_out%0d cyc=%0d got=%h exp=%h", k, c, dout[k], mlast[k]);
                end
`ifdef DEMUX_XFER_COUNT_EN
                checks++;
                if (dcnt[k] !== 8'(mcnt[k])) begin
                    errors++; $display("FAIL rand_cnt%0d cyc=%0d got=%h exp=%h", k, c, dcnt[k], 8'(mcnt[k]));
                end
`endif
            end
        end
        rst = 1'b0;
    endtask

`ifdef DEMUX_XFER_COUNT_EN
    task automatic test_counter();
        do_reset();
        in_valid = 1'b1; sel = 2'd0; out_ready = 4'b0001;
        for (int c = 0; c < 301; c++) begin
            in_data = 8'(c);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 4'b0000;
        #1;
        checks++;
        if (cnt0 !== 8'hFF) begin errors++; $display("FAIL cnt_sat got=%h exp=ff", cnt0); end
        checks++;
        if ({cnt1, cnt2, cnt3} !== 24'h0) begin
            errors++; $display("FAIL cnt_others got=%h exp=000000", {cnt1, cnt2, cnt3});
        end
    endtask
`endif

    initial begin
        rst = 1'b1; in_valid = 1'b0; sel = 2'd0; in_data = 8'h00; out_ready = 4'b0000;
        for (int k = 0; k < 4; k++) begin mlast[k] = 8'h00; mcnt[k] = 0; end
        @(negedge clk);
        test_reset();
        test_routing();
        test_backpressure();
        test_streaming();
        test_parallel_drain();
        test_reset_mid();
        test_random();
`ifdef DEMUX_XFER_COUNT_EN
        test_counter();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
